somador_serial_ctrl: RTL



---
 rtl/somador_serial_ctrl_if.sv | 24 ++
 rtl/somador_serial_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/somador_serial_ctrl_if.sv
// Handshake/operand bundle for the serial nibble adder.
// The requester drives start/operands; the adder returns status and result.
interface somador_serial_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/somador_serial_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit ripple adder processes one nibble
// per clock, LSB first, with carry fed back through a register.
module somador_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    somador_serial_ctrl_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [NIB-1:0][3:0] nib_vec_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic            carry_q, carry_d;
    nib_vec_t        a_q,     a_d;
    nib_vec_t        b_q,     b_d;
    nib_vec_t        sum_q,   sum_d;
    logic            cout_q,  cout_d;

    logic [3:0] add_sum;
    logic       add_cout;
    logic       last_nib;

    // One full-adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // Four cells chained LSB to MSB; the carry ripples through a local variable.
    always_comb begin
        logic       c;
        logic [1:0] fa;
        c       = carry_q;
        add_sum = '0;
        for (int i = 0; i < 4; i++) begin
            fa         = full_add(a_q[idx_q][i], b_q[idx_q][i], c);
            add_sum[i] = fa[0];
            c          = fa[1];
        end
        add_cout = c;
    end

    assign last_nib = (idx_q == IDXW'(NIB - 1));

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (last_nib) begin
                    cout_d  = add_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order. The operand registers are
    // plain flops rather than a RAM, so resetting them along with the rest is
    // cheap and keeps the post-reset state fully defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
